y2r_csc_pipe: RTL and testbench

- Pipelined YUV-to-RGB colour-space converter.
- Sits directly downstream of the para_ctrl parameter stage:
  - consumes its shift_bit policy and its round_num / offset_en outputs;
  - consumes the 3x3 y2r coefficient matrix and the per-channel offsets.
- Applies them to a valid/ready pixel stream: matrix multiply, offset, rounding, arithmetic shift, clip to 8 bits.
- Parameters are shadowed and swapped only when the pipeline is empty.

---
 rtl/y2r_pkg.sv | 31 +++
 rtl/y2r_row_mac.sv | 80 ++++++++
 rtl/y2r_csc_pipe.sv | 144 ++++++++++++++
 tb/tb_y2r_csc_pipe.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/y2r_pkg.sv
// Shared constants, FSM state type and config helper for the y2r colour-space converter.
// Vectors are packed MSB-first: c00 / o0 / y / r occupy the top slice of their bus.
package y2r_pkg;

    localparam int PARA_DW = 12;
    localparam int PIX_DW  = 8;
    localparam int ACC_W   = 24;
    localparam int OFS_W   = PARA_DW + 8;
    localparam int PROD_W  = PIX_DW + PARA_DW + 1;

    localparam logic [4:0] SHIFT_MIN = 5'd8;
    localparam logic [4:0] SHIFT_MAX = 5'd17;

    typedef enum logic {
        RUN  = 1'b0,
        PEND = 1'b1
    } cfg_state_e;

    function automatic logic [4:0] clamp_shift(input logic [4:0] raw);
        logic [4:0] res;
        if (raw < SHIFT_MIN) begin
            res = SHIFT_MIN;
        end else if (raw > SHIFT_MAX) begin
            res = SHIFT_MAX;
        end else begin
            res = raw;
        end
        return res;
    endfunction

endpackage

// File: rtl/y2r_row_mac.sv
// One output row of the converter: three products, offset/round bias, arithmetic
// shift and clip to an unsigned pixel, across three stall-gated pipeline stages.
module y2r_row_mac
    import y2r_pkg::*;
(
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 i_en,
    input  logic [3*PIX_DW-1:0]  i_pix,
    input  logic [3*PARA_DW-1:0] i_coef,
    input  logic [OFS_W-1:0]     i_offset,
    input  logic                 i_offset_en,
    input  logic [7:0]           i_round,
    input  logic [4:0]           i_shift,
    output logic [PIX_DW-1:0]    o_res
);

    logic signed [PROD_W-1:0] w_prod [3];
    logic signed [PROD_W-1:0] r_prod [3];
    logic signed [ACC_W-1:0]  w_acc;
    logic signed [ACC_W-1:0]  r_acc;
    logic signed [ACC_W-1:0]  w_shr;
    logic [PIX_DW-1:0]        w_clip;
    logic [PIX_DW-1:0]        r_res;

    // S1 products: pixel zero-extended, coefficient sign-extended to the product width
    always_comb begin
        for (int k = 0; k < 3; k++) begin
            w_prod[k] = $signed({{(PROD_W-PIX_DW){1'b0}}, i_pix[(2-k)*PIX_DW +: PIX_DW]})
                      * $signed({{(PROD_W-PARA_DW){i_coef[(2-k)*PARA_DW + PARA_DW - 1]}},
                                 i_coef[(2-k)*PARA_DW +: PARA_DW]});
        end
    end

    // S2 accumulation of products, optional offset, round bias and half-LSB of the shift
    always_comb begin
        w_acc = {{(ACC_W-PROD_W){r_prod[0][PROD_W-1]}}, r_prod[0]}
              + {{(ACC_W-PROD_W){r_prod[1][PROD_W-1]}}, r_prod[1]}
              + {{(ACC_W-PROD_W){r_prod[2][PROD_W-1]}}, r_prod[2]}
              + {{(ACC_W-8){1'b0}}, i_round}
              + ({{(ACC_W-1){1'b0}}, 1'b1} << (i_shift - 5'd1));
        if (i_offset_en) begin
            w_acc = w_acc + {{(ACC_W-OFS_W){i_offset[OFS_W-1]}}, i_offset};
        end else begin
            w_acc = w_acc;
        end
    end

    // S3 arithmetic shift and saturation into the unsigned pixel range
    always_comb begin
        w_shr = r_acc >>> i_shift;
        if (w_shr[ACC_W-1]) begin
            w_clip = {PIX_DW{1'b0}};
        end else if (|w_shr[ACC_W-2:PIX_DW]) begin
            w_clip = {PIX_DW{1'b1}};
        end else begin
            w_clip = w_shr[PIX_DW-1:0];
        end
    end

    // Pipeline registers, all advancing together on the shared enable
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int k = 0; k < 3; k++) begin
                r_prod[k] <= '0;
            end
            r_acc <= '0;
            r_res <= '0;
        end else if (i_en) begin
            for (int k = 0; k < 3; k++) begin
                r_prod[k] <= w_prod[k];
            end
            r_acc <= w_acc;
            r_res <= w_clip;
        end
    end

    assign o_res = r_res;

endmodule

// File: rtl/y2r_csc_pipe.sv
// Pipelined YUV-to-RGB converter with shadowed configuration that is swapped in
// only once every in-flight pixel has left the pipeline.
module y2r_csc_pipe
    import y2r_pkg::*;
(
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 cfg_load,
    input  logic [9*PARA_DW-1:0] cfg_coef,
    input  logic [3*OFS_W-1:0]   cfg_offset,
    input  logic [4:0]           cfg_shift,
    input  logic [7:0]           cfg_round,
    input  logic                 cfg_offset_en,
    output logic                 cfg_busy,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [3*PIX_DW-1:0]  in_pix,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [3*PIX_DW-1:0]  out_pix
);

    cfg_state_e           r_state;
    cfg_state_e           w_state_nxt;
    logic [9*PARA_DW-1:0] r_sh_coef;
    logic [9*PARA_DW-1:0] r_act_coef;
    logic [3*OFS_W-1:0]   r_sh_ofs;
    logic [3*OFS_W-1:0]   r_act_ofs;
    logic [4:0]           r_sh_shift;
    logic [4:0]           r_act_shift;
    logic [7:0]           r_sh_round;
    logic [7:0]           r_act_round;
    logic                 r_sh_oe;
    logic                 r_act_oe;
    logic                 r_v1;
    logic                 r_v2;
    logic                 r_v3;
    logic                 w_adv;
    logic                 w_accept;
    logic                 w_empty;
    logic                 w_swap;
    logic [3*PIX_DW-1:0]  w_res;

    assign w_adv     = !r_v3 || out_ready;
    assign in_ready  = w_adv && (r_state == RUN);
    assign w_accept  = in_valid && in_ready;
    assign w_empty   = !r_v1 && !r_v2 && !r_v3;
    // A fresh load in PEND restarts the wait so the newest shadow is the one applied
    assign w_swap    = (r_state == PEND) && w_empty && !cfg_load;
    assign cfg_busy  = (r_state == PEND);
    assign out_valid = r_v3;
    assign out_pix   = w_res;

    // Config FSM state register
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Config FSM next-state decode
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            RUN: begin
                if (cfg_load) begin
                    w_state_nxt = PEND;
                end else begin
                    w_state_nxt = RUN;
                end
            end
            PEND: begin
                if (w_swap) begin
                    w_state_nxt = RUN;
                end else begin
                    w_state_nxt = PEND;
                end
            end
            default: w_state_nxt = RUN;
        endcase
    end

    // Shadow capture on every load and shadow-to-active copy at the swap
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_sh_coef   <= '0;
            r_sh_ofs    <= '0;
            r_sh_shift  <= SHIFT_MIN;
            r_sh_round  <= 8'd0;
            r_sh_oe     <= 1'b0;
            r_act_coef  <= '0;
            r_act_ofs   <= '0;
            r_act_shift <= SHIFT_MIN;
            r_act_round <= 8'd0;
            r_act_oe    <= 1'b0;
        end else begin
            if (cfg_load) begin
                r_sh_coef  <= cfg_coef;
                r_sh_ofs   <= cfg_offset;
                r_sh_shift <= clamp_shift(cfg_shift);
                r_sh_round <= cfg_round;
                r_sh_oe    <= cfg_offset_en;
            end
            if (w_swap) begin
                r_act_coef  <= r_sh_coef;
                r_act_ofs   <= r_sh_ofs;
                r_act_shift <= r_sh_shift;
                r_act_round <= r_sh_round;
                r_act_oe    <= r_sh_oe;
            end
        end
    end

    // Stage valid flags under the global stall
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_v1 <= 1'b0;
            r_v2 <= 1'b0;
            r_v3 <= 1'b0;
        end else if (w_adv) begin
            r_v1 <= w_accept;
            r_v2 <= r_v1;
            r_v3 <= r_v2;
        end
    end

    for (genvar j = 0; j < 3; j++) begin : g_row
        y2r_row_mac u_row (
            .clk_in      (clk_in),
            .rst_in      (rst_in),
            .i_en        (w_adv),
            .i_pix       (in_pix),
            .i_coef      (r_act_coef[(2-j)*3*PARA_DW +: 3*PARA_DW]),
            .i_offset    (r_act_ofs[(2-j)*OFS_W +: OFS_W]),
            .i_offset_en (r_act_oe),
            .i_round     (r_act_round),
            .i_shift     (r_act_shift),
            .o_res       (w_res[(2-j)*PIX_DW +: PIX_DW])
        );
    end

endmodule

// File: tb/tb_y2r_csc_pipe.sv
// Self-checking bench for y2r_csc_pipe: a per-pixel arithmetic model tagged with the
// config in force at acceptance, plus directed vectors with hand-computed results.
module tb_y2r_csc_pipe;
    import y2r_pkg::*;

    logic                 clk_in = 1'b0;
    logic                 rst_in;
    logic                 cfg_load;
    logic [9*PARA_DW-1:0] cfg_coef;
    logic [3*OFS_W-1:0]   cfg_offset;
    logic [4:0]           cfg_shift;
    logic [7:0]           cfg_round;
    logic                 cfg_offset_en;
    logic                 cfg_busy;
    logic                 in_valid;
    logic                 in_ready;
    logic [3*PIX_DW-1:0]  in_pix;
    logic                 out_valid;
    logic                 out_ready;
    logic [3*PIX_DW-1:0]  out_pix;

    int b_c [9];
    int b_o [3];
    int b_sh;
    int b_rd;
    int b_oe;
    int m_c [9];
    int m_o [3];
    int m_sh;
    int m_rd;
    int m_oe;

    logic [23:0] q [$];
    logic [23:0] got [$];
    int          n_cmp  = 0;
    int          n_fail = 0;
    logic        stalled_prev = 1'b0;
    logic [23:0] prev_pix = 24'd0;

    always #5 clk_in = ~clk_in;

    y2r_csc_pipe dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .cfg_load      (cfg_load),
        .cfg_coef      (cfg_coef),
        .cfg_offset    (cfg_offset),
        .cfg_shift     (cfg_shift),
        .cfg_round     (cfg_round),
        .cfg_offset_en (cfg_offset_en),
        .cfg_busy      (cfg_busy),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_pix        (in_pix),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_pix       (out_pix)
    );

    always_comb begin
        cfg_coef   = '0;
        cfg_offset = '0;
        for (int i = 0; i < 9; i++) cfg_coef[(8-i)*PARA_DW +: PARA_DW] = b_c[i][PARA_DW-1:0];
        for (int i = 0; i < 3; i++) cfg_offset[(2-i)*OFS_W +: OFS_W] = b_o[i][OFS_W-1:0];
        cfg_shift     = b_sh[4:0];
        cfg_round     = b_rd[7:0];
        cfg_offset_en = b_oe[0];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [23:0] model_rgb(input logic [23:0] p);
        int comp [3];
        int acc;
        int r;
        logic [23:0] res;
        comp[0] = int'(p[23:16]);
        comp[1] = int'(p[15:8]);
        comp[2] = int'(p[7:0]);
        res = 24'd0;
        for (int j = 0; j < 3; j++) begin
            acc = m_rd + (1 << (m_sh - 1));
            if (m_oe != 0) acc += m_o[j];
            for (int k = 0; k < 3; k++) acc += comp[k] * m_c[3*j+k];
            r = acc >>> m_sh;
            if (r < 0) r = 0;
            else if (r > 255) r = 255;
            res[(2-j)*8 +: 8] = r[7:0];
        end
        return res;
    endfunction

    // Monitor/model: sampled on the falling edge, mirrors what the next rising edge commits
    always @(negedge clk_in) begin
        if (rst_in) begin
            q.delete();
            stalled_prev = 1'b0;
            for (int i = 0; i < 9; i++) m_c[i] = 0;
            for (int i = 0; i < 3; i++) m_o[i] = 0;
            m_sh = 8; m_rd = 0; m_oe = 0;
        end else begin
            if (stalled_prev) begin
                chk("hold_valid", 32'(out_valid), 32'd1);
                chk("hold_pix", 32'(out_pix), 32'(prev_pix));
            end
            if (out_valid) begin
                if (q.size() == 0) chk("out_valid_without_pixel", 32'(out_valid), 32'd0);
                else chk("stream_pix", 32'(out_pix), 32'(q[0]));
            end
            stalled_prev = out_valid && !out_ready;
            prev_pix     = out_pix;
            if (out_valid && out_ready && q.size() > 0) begin
                got.push_back(out_pix);
                void'(q.pop_front());
            end
            if (in_valid && in_ready) q.push_back(model_rgb(in_pix));
            if (cfg_load) begin
                for (int i = 0; i < 9; i++) m_c[i] = b_c[i];
                for (int i = 0; i < 3; i++) m_o[i] = b_o[i];
                m_sh = (b_sh < 8) ? 8 : ((b_sh > 17) ? 17 : b_sh);
                m_rd = b_rd;
                m_oe = b_oe;
            end
        end
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic do_reset();
        rst_in = 1'b1; in_valid = 1'b0; cfg_load = 1'b0;
        tick(); tick();
        rst_in = 1'b0;
    endtask

    task automatic wait_idle_cfg();
        int n = 0;
        while (cfg_busy && n < 100) begin tick(); n++; end
        if (n >= 100) chk("cfg_busy_timeout", 32'd1, 32'd0);
    endtask

    task automatic load_cfg();
        cfg_load = 1'b1;
        tick();
        cfg_load = 1'b0;
        wait_idle_cfg();
    endtask

    task automatic send(input logic [23:0] p);
        int n = 0;
        in_pix = p; in_valid = 1'b1;
        #1;
        while (!in_ready && n < 100) begin tick(); #1; n++; end
        if (n >= 100) chk("in_ready_timeout", 32'd1, 32'd0);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        out_ready = 1'b1;
        while ((q.size() != 0 || out_valid) && n < 100) begin tick(); n++; end
        if (n >= 100) chk("drain_timeout", 32'd1, 32'd0);
    endtask

    task automatic expect_last(input string name, input logic [23:0] exp);
        if (got.size() == 0) chk(name, 32'hFFFF_FFFF, 32'(exp));
        else chk(name, 32'(got[got.size()-1]), 32'(exp));
    endtask

    task automatic set_ident();
        for (int i = 0; i < 9; i++) b_c[i] = 0;
        b_c[0] = 256; b_c[4] = 256; b_c[8] = 256;
        for (int i = 0; i < 3; i++) b_o[i] = 0;
        b_sh = 8; b_rd = 0; b_oe = 0;
    endtask

    task automatic set_c00(input int c, input int sh);
        for (int i = 0; i < 9; i++) b_c[i] = 0;
        b_c[0] = c;
        for (int i = 0; i < 3; i++) b_o[i] = 0;
        b_sh = sh; b_rd = 0; b_oe = 0;
    endtask

    logic [23:0] stream [10] = '{24'h108080, 24'hEB8080, 24'h515AF0, 24'h913622, 24'h29F06E,
                                 24'h000000, 24'hFFFFFF, 24'h8040C0, 24'hC80AFA, 24'h3CB414};

    initial begin
        int g0;
        int busy_cnt;
        rst_in = 1'b1; cfg_load = 1'b0; in_valid = 1'b0; in_pix = 24'd0; out_ready = 1'b1;
        set_c00(0, 8);
        do_reset();

        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_pix", 32'(out_pix), 32'd0);
        chk("rst_cfg_busy", 32'(cfg_busy), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        send(24'h6432C8); drain();
        expect_last("rst_cfg_zero", 24'h000000);

        // identity with exact three-cycle latency
        set_ident(); load_cfg();
        in_pix = 24'h6432C8; in_valid = 1'b1;
        chk("ident_in_ready", 32'(in_ready), 32'd1);
        tick(); in_valid = 1'b0;
        chk("lat_after_1", 32'(out_valid), 32'd0);
        tick();
        chk("lat_after_2", 32'(out_valid), 32'd0);
        tick();
        chk("lat_after_3", 32'(out_valid), 32'd1);
        chk("ident_pix", 32'(out_pix), 32'h6432C8);
        drain();

        // offsets on and off
        for (int i = 0; i < 3; i++) b_o[i] = 4096;
        b_oe = 1; load_cfg();
        send(24'h646464); drain(); expect_last("offset_en", 24'h747474);
        b_oe = 0; load_cfg();
        send(24'h646464); drain(); expect_last("offset_dis", 24'h646464);

        // rounding bias
        set_ident(); b_rd = 200; load_cfg();
        send(24'h6432C8); drain(); expect_last("round_200", 24'h6533C9);

        // clipping both ends
        set_c00(2047, 8); load_cfg();
        send(24'hFF4D21); drain(); expect_last("clip_high", 24'hFF0000);
        set_c00(-2048, 8); load_cfg();
        send(24'hFF4D21); drain(); expect_last("clip_low", 24'h000000);

        // shift clamp at both ends
        set_ident(); b_sh = 3; load_cfg();
        send(24'h6432C8); drain(); expect_last("shift_clamp_lo", 24'h6432C8);
        set_c00(2047, 20); load_cfg();
        send(24'hFF0000); drain(); expect_last("shift_clamp_hi", 24'h040000);

        // backpressure burst with a realistic conversion matrix
        b_c = '{256, 0, 359, 256, -88, -183, 256, 454, 0};
        b_o = '{-45952, 34688, -58112};
        b_sh = 8; b_rd = 5; b_oe = 1; load_cfg();
        g0 = got.size();
        fork
            begin
                for (int i = 0; i < 10; i++) send(stream[i]);
            end
            begin
                repeat (6) tick();
                out_ready = 1'b0;
                repeat (5) tick();
                out_ready = 1'b1;
            end
        join
        drain();
        chk("burst_count", 32'(got.size() - g0), 32'd10);

        // config load with three pixels in flight
        set_ident(); load_cfg();
        in_valid = 1'b1;
        in_pix = 24'h0A141E; tick();
        in_pix = 24'h28323C; tick();
        in_pix = 24'h46505A; tick();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) b_o[i] = 4096;
        b_oe = 1;
        cfg_load = 1'b1; tick(); cfg_load = 1'b0;
        in_pix = 24'h646464; in_valid = 1'b1;
        busy_cnt = 0;
        while (cfg_busy && busy_cnt < 50) begin
            chk("pend_in_ready", 32'(in_ready), 32'd0);
            busy_cnt++; tick();
        end
        chk("busy_cycles", 32'(busy_cnt), 32'd3);
        chk("swap_in_ready", 32'(in_ready), 32'd1);
        tick(); in_valid = 1'b0;
        drain();
        chk("mid_a", 32'(got[got.size()-4]), 32'h0A141E);
        chk("mid_b", 32'(got[got.size()-3]), 32'h28323C);
        chk("mid_c", 32'(got[got.size()-2]), 32'h46505A);
        expect_last("mid_d_newcfg", 24'h747474);

        // simultaneous load and pixel keeps the old config for that pixel
        b_oe = 0;
        in_pix = 24'h646464; in_valid = 1'b1; cfg_load = 1'b1;
        chk("simul_in_ready", 32'(in_ready), 32'd1);
        tick(); in_valid = 1'b0; cfg_load = 1'b0;
        wait_idle_cfg(); drain();
        expect_last("simul_oldcfg", 24'h747474);
        send(24'h646464); drain(); expect_last("simul_newcfg", 24'h646464);

        // second load while pending overwrites the shadow
        out_ready = 1'b0;
        send(24'h112233); repeat (3) tick();
        set_c00(2047, 8); cfg_load = 1'b1; tick(); cfg_load = 1'b0;
        set_ident(); cfg_load = 1'b1; tick(); cfg_load = 1'b0;
        chk("pend_overwrite_busy", 32'(cfg_busy), 32'd1);
        out_ready = 1'b1; wait_idle_cfg(); drain();
        send(24'h6432C8); drain(); expect_last("pend_overwrite", 24'h6432C8);

        // reset with a pending config and a stuck pixel
        out_ready = 1'b0;
        send(24'h808080); repeat (3) tick();
        for (int i = 0; i < 3; i++) b_o[i] = 4096;
        b_oe = 1; cfg_load = 1'b1; tick(); cfg_load = 1'b0;
        chk("pre_reset_busy", 32'(cfg_busy), 32'd1);
        do_reset();
        chk("post_reset_busy", 32'(cfg_busy), 32'd0);
        chk("post_reset_valid", 32'(out_valid), 32'd0);
        out_ready = 1'b1;
        send(24'h6432C8); drain(); expect_last("post_reset_cfg", 24'h000000);

        chk("final_queue_empty", 32'(q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got time %0t, expected finish", $time);
        $fatal(1);
    end

endmodule
